// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution feeder.
package conv_pkg;

    // Rows and columns of the convolution kernel.
    localparam int unsigned KERNEL_DIM = 3;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StIssue,
        StGuard,
        StWaitRdy,
        StFlush,
        StCfIssue,
        StCf0,
        StCf1,
        StCf2,
        StDone
    } feeder_state_e;

    // Request raised in StIssue; PkNewRow doubles as the controller's S0 load.
    typedef enum logic {
        PkSample,
        PkNewRow
    } pulse_kind_e;

endpackage

// File: rtl/conv_coeff_shadow.sv
// Coefficient shadow, transfer snapshot, pending flag and coeff_data column mux.
module conv_coeff_shadow
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                                     clk_i,
    input  logic                                     n_rst_i,
    input  logic                                     coeff_wr_i,
    input  logic [KERNEL_DIM*KERNEL_DIM*DATA_W-1:0] coeff_in_i,
    input  logic                                     snap_en_i,
    input  logic                                     col_en_i,
    input  logic [1:0]                               col_sel_i,
    output logic [KERNEL_DIM*DATA_W-1:0]             coeff_data_o,
    output logic                                     pending_o
);

    localparam int unsigned ColW    = KERNEL_DIM * DATA_W;
    localparam int unsigned KernelW = KERNEL_DIM * ColW;

    logic [KernelW-1:0] shadow_q, shadow_d;
    logic [KernelW-1:0] snapshot_q, snapshot_d;
    logic               pending_q, pending_d;

    // State registers.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            shadow_q   <= '0;
            snapshot_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            snapshot_q <= snapshot_d;
            pending_q  <= pending_d;
        end
    end

    // A host write in the snapshot cycle wins, so a late update stays pending.
    always_comb begin
        shadow_d   = shadow_q;
        snapshot_d = snapshot_q;
        pending_d  = pending_q;
        if (snap_en_i) begin
            snapshot_d = shadow_q;
            pending_d  = 1'b0;
        end
        if (coeff_wr_i) begin
            shadow_d  = coeff_in_i;
            pending_d = 1'b1;
        end
    end

    // Column mux from the snapshot; zero outside the transfer cycles.
    always_comb begin
        coeff_data_o = '0;
        if (col_en_i) begin
            unique case (col_sel_i)
                2'd0:    coeff_data_o = snapshot_q[ColW-1:0];
                2'd1:    coeff_data_o = snapshot_q[2*ColW-1:ColW];
                2'd2:    coeff_data_o = snapshot_q[3*ColW-1:2*ColW];
                default: coeff_data_o = '0;
            endcase
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/conv_feeder.sv
// Request sequencer feeding image columns and kernel updates to the conv controller.
module conv_feeder
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                                     clk_i,
    input  logic                                     n_rst_i,
    input  logic                                     start_i,
    input  logic                                     coeff_wr_i,
    input  logic [KERNEL_DIM*KERNEL_DIM*DATA_W-1:0] coeff_in_i,
    input  logic                                     modwait_i,
    output logic                                     mem_rd_en_o,
    output logic [ADDR_W-1:0]                        mem_addr_o,
    input  logic [KERNEL_DIM*DATA_W-1:0]             mem_rdata_i,
    output logic                                     sample_load_en_o,
    output logic                                     new_row_o,
    output logic                                     coeff_load_en_o,
    output logic [KERNEL_DIM*DATA_W-1:0]             sample_data_o,
    output logic [KERNEL_DIM*DATA_W-1:0]             coeff_data_o,
    output logic                                     busy_o,
    output logic                                     done_o
);

    localparam int unsigned ColCntW = $clog2(IMG_W);
    localparam int unsigned RowCntW = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;

    feeder_state_e                  state_q, state_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [ColCntW-1:0]             col_q, col_d;
    logic [RowCntW-1:0]             row_q, row_d;
    logic [KERNEL_DIM*DATA_W-1:0]   sample_data_q, sample_data_d;

    pulse_kind_e pulse_kind;
    logic        last_col;
    logic        last_row;
    logic        snap_en;
    logic        cf_col_en;
    logic [1:0]  cf_col_sel;
    logic        pending;

    conv_coeff_shadow #(
        .DATA_W (DATA_W)
    ) u_coeff_shadow (
        .clk_i        (clk_i),
        .n_rst_i      (n_rst_i),
        .coeff_wr_i   (coeff_wr_i),
        .coeff_in_i   (coeff_in_i),
        .snap_en_i    (snap_en),
        .col_en_i     (cf_col_en),
        .col_sel_i    (cf_col_sel),
        .coeff_data_o (coeff_data_o),
        .pending_o    (pending)
    );

    // State, counters and the held sample column.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            sample_data_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            col_q         <= col_d;
            row_q         <= row_d;
            sample_data_q <= sample_data_d;
        end
    end

    // Next state, counter advance and request strobes.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        col_d            = col_q;
        row_d            = row_q;
        sample_data_d    = sample_data_q;
        mem_rd_en_o      = 1'b0;
        sample_load_en_o = 1'b0;
        new_row_o        = 1'b0;
        coeff_load_en_o  = 1'b0;
        done_o           = 1'b0;
        snap_en          = 1'b0;
        cf_col_en        = 1'b0;
        cf_col_sel       = 2'd0;

        last_col   = (col_q == ColCntW'(IMG_W - 1));
        last_row   = (row_q == RowCntW'(IMG_H - 3));
        pulse_kind = ((col_q == '0) && (row_q != '0)) ? PkNewRow : PkSample;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StFetch: begin
                mem_rd_en_o = 1'b1;
                state_d     = StIssue;
            end
            StIssue: begin
                if (pulse_kind == PkNewRow) begin
                    new_row_o = 1'b1;
                end else begin
                    sample_load_en_o = 1'b1;
                end
                sample_data_d = mem_rdata_i;
                state_d       = StGuard;
            end
            // Controller may not have raised modwait yet; skip one cycle.
            StGuard: begin
                state_d = StWaitRdy;
            end
            StWaitRdy: begin
                if (!modwait_i) begin
                    if (last_col && last_row) begin
                        state_d = pending ? StCfIssue : StFlush;
                    end else begin
                        state_d = StFetch;
                        addr_d  = addr_q + ADDR_W'(1);
                        if (last_col) begin
                            col_d = '0;
                            row_d = row_q + RowCntW'(1);
                        end else begin
                            col_d = col_q + ColCntW'(1);
                        end
                    end
                end
            end
            // Both strobes together send the controller back to idle.
            StFlush: begin
                new_row_o        = 1'b1;
                sample_load_en_o = 1'b1;
                state_d          = StDone;
            end
            StCfIssue: begin
                coeff_load_en_o = 1'b1;
                snap_en         = 1'b1;
                state_d         = StCf0;
            end
            StCf0: begin
                cf_col_en  = 1'b1;
                cf_col_sel = 2'd0;
                state_d    = StCf1;
            end
            StCf1: begin
                cf_col_en  = 1'b1;
                cf_col_sel = 2'd1;
                state_d    = StCf2;
            end
            StCf2: begin
                cf_col_en  = 1'b1;
                cf_col_sel = 2'd2;
                state_d    = StDone;
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_addr_o    = addr_q;
    assign sample_data_o = sample_data_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_conv_feeder.sv
// Scoreboard bench for conv_feeder on a 4x4 image with a modelled controller.
module tb_conv_feeder;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;

    localparam int EvRd     = 0;
    localparam int EvSample = 1;
    localparam int EvNewRow = 2;
    localparam int EvFlush  = 3;
    localparam int EvCf     = 4;
    localparam int EvDone   = 5;

    typedef struct {
        int          kind;
        logic [71:0] data;
    } exp_t;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic          coeff_wr;
    logic [71:0]   coeff_in;
    logic          modwait;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_rdata;
    logic          sle;
    logic          nr;
    logic          cle;
    logic [23:0]   sample_data;
    logic [23:0]   coeff_data;
    logic          busy;
    logic          done;

    exp_t        exp_q[$];
    int          tests;
    int          fails;
    int          done_cnt;
    int          pulse_idx;
    int          stall_target;
    int          mw_cnt;
    logic [71:0] m_shadow;
    bit          m_pending;

    conv_feeder #(
        .IMG_W  (W),
        .IMG_H  (H),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk_i            (clk),
        .n_rst_i          (n_rst),
        .start_i          (start),
        .coeff_wr_i       (coeff_wr),
        .coeff_in_i       (coeff_in),
        .modwait_i        (modwait),
        .mem_rd_en_o      (mem_rd_en),
        .mem_addr_o       (mem_addr),
        .mem_rdata_i      (mem_rdata),
        .sample_load_en_o (sle),
        .new_row_o        (nr),
        .coeff_load_en_o  (cle),
        .sample_data_o    (sample_data),
        .coeff_data_o     (coeff_data),
        .busy_o           (busy),
        .done_o           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line memory: each column word equals its address.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= 24'(mem_addr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a whole frame's expected events from image geometry alone.
    task automatic push_frame();
        exp_t e;
        for (int r = 0; r < int'(H) - 2; r++) begin
            for (int c = 0; c < int'(W); c++) begin
                e.kind = EvRd;
                e.data = 72'(r * int'(W) + c);
                exp_q.push_back(e);
                e.kind = (c == 0 && r > 0) ? EvNewRow : EvSample;
                exp_q.push_back(e);
            end
        end
        if (m_pending) begin
            e.kind    = EvCf;
            e.data    = m_shadow;
            m_pending = 1'b0;
        end else begin
            e.kind = EvFlush;
            e.data = '0;
        end
        exp_q.push_back(e);
        e.kind = EvDone;
        e.data = '0;
        exp_q.push_back(e);
    endtask

    // Controller model: busy for a random stretch after every sample request.
    initial begin
        modwait   = 1'b0;
        mw_cnt    = 0;
        pulse_idx = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                mw_cnt  = 0;
                modwait = 1'b0;
            end else begin
                if (sle || nr || cle || mem_rd_en) chk("req_while_modwait", 72'(modwait), 72'(0));
                if (mw_cnt > 0) begin
                    mw_cnt--;
                    if (mw_cnt == 0) modwait = 1'b0;
                end
                if ((sle || nr) && !(sle && nr)) begin
                    pulse_idx++;
                    mw_cnt  = $urandom_range(4, 1) + ((pulse_idx == stall_target) ? 5 : 0);
                    modwait = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows an event.
    initial begin
        int          k;
        bit          ev;
        logic [71:0] d;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                ev = 1'b1;
                d  = '0;
                k  = -1;
                if (done) done_cnt++;
                if (int'(sle) + int'(nr) + int'(cle) + int'(mem_rd_en) + int'(done) > 1
                    && !(sle && nr && !cle && !mem_rd_en && !done))
                    chk("exclusive_strobes", {68'd0, sle, nr, cle, mem_rd_en}, 72'd0);
                if (mem_rd_en) begin
                    k = EvRd;
                    d = 72'(mem_addr);
                end else if (sle && nr) k = EvFlush;
                else if (nr) k = EvNewRow;
                else if (sle) k = EvSample;
                else if (cle) k = EvCf;
                else if (done) k = EvDone;
                else ev = 1'b0;

                if (!ev) begin
                    chk("coeff_data_idle", 72'(coeff_data), 72'd0);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_event", 72'(k), 72'hFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 72'(k), 72'(e.kind));
                    if (k == e.kind) begin
                        if (k == EvRd) begin
                            chk("read_addr", d, e.data);
                        end else if (k == EvSample || k == EvNewRow) begin
                            @(negedge clk);
                            chk("sample_data", 72'(sample_data), 72'(e.data[23:0]));
                        end else if (k == EvCf) begin
                            for (int j = 0; j < 3; j++) begin
                                @(negedge clk);
                                chk("coeff_col", 72'(coeff_data), 72'(e.data[24*j +: 24]));
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic write_coeff(input logic [71:0] k);
        @(negedge clk);
        coeff_wr = 1'b1;
        coeff_in = k;
        @(negedge clk);
        coeff_wr  = 1'b0;
        m_shadow  = k;
        m_pending = 1'b1;
    endtask

    task automatic run_frame(input bit busy_start, input bit cf1_wr, input logic [71:0] k2);
        int d0;
        int n;
        push_frame();
        d0 = done_cnt;
        pulse_start();
        chk("busy_after_start", 72'(busy), 72'd1);
        if (busy_start) begin
            repeat (10) @(negedge clk);
            pulse_start();
        end
        if (cf1_wr) begin
            n = 0;
            while (!cle && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) chk("wait_coeff_load_timeout", 72'(n), 72'd0);
            @(negedge clk);
            @(negedge clk);
            coeff_wr = 1'b1;
            coeff_in = k2;
            @(negedge clk);
            coeff_wr  = 1'b0;
            m_shadow  = k2;
            m_pending = 1'b1;
        end
        n = 0;
        while (done_cnt == d0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) chk("wait_done_timeout", 72'(n), 72'd0);
        repeat (2) @(negedge clk);
        chk("busy_idle", 72'(busy), 72'd0);
        chk("queue_drained", 72'(exp_q.size()), 72'd0);
        chk("done_count", 72'(done_cnt - d0), 72'd1);
    endtask

    initial begin
        int n;
        int d0;
        tests        = 0;
        fails        = 0;
        done_cnt     = 0;
        stall_target = -1;
        m_shadow     = '0;
        m_pending    = 1'b0;
        start        = 1'b0;
        coeff_wr     = 1'b0;
        coeff_in     = '0;
        n_rst        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_rd_en", 72'(mem_rd_en), 72'd0);
        chk("rst_mem_addr", 72'(mem_addr), 72'd0);
        chk("rst_sle", 72'(sle), 72'd0);
        chk("rst_new_row", 72'(nr), 72'd0);
        chk("rst_cle", 72'(cle), 72'd0);
        chk("rst_sample_data", 72'(sample_data), 72'd0);
        chk("rst_coeff_data", 72'(coeff_data), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_done", 72'(done), 72'd0);
        n_rst = 1'b1;

        // Plain frame ends with a flush.
        run_frame(1'b0, 1'b0, '0);
        // Kernel written before start is transferred at frame end.
        write_coeff(72'h070809_040506_010203);
        run_frame(1'b0, 1'b0, '0);
        // Long controller stall on the third request.
        stall_target = pulse_idx + 3;
        run_frame(1'b0, 1'b0, '0);
        stall_target = -1;
        // New kernel arriving during CF1 must not disturb the transfer.
        write_coeff({$urandom(), $urandom(), 8'($urandom())});
        run_frame(1'b0, 1'b1, {$urandom(), $urandom(), 8'($urandom())});
        run_frame(1'b0, 1'b0, '0);
        // Start while busy is ignored.
        run_frame(1'b1, 1'b0, '0);

        // Reset while waiting on the controller at address 5.
        write_coeff({$urandom(), $urandom(), 8'($urandom())});
        push_frame();
        pulse_start();
        n = 0;
        while (!(mem_rd_en && mem_addr == AW'(5)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("wait_addr5_timeout", 72'(n), 72'd0);
        repeat (3) @(negedge clk);
        chk("wait_rdy_addr", 72'(mem_addr), 72'd5);
        d0    = done_cnt;
        n_rst = 1'b0;
        exp_q.delete();
        m_pending = 1'b0;
        m_shadow  = '0;
        @(negedge clk);
        chk("mid_rst_busy", 72'(busy), 72'd0);
        chk("mid_rst_mem_addr", 72'(mem_addr), 72'd0);
        chk("mid_rst_sample_data", 72'(sample_data), 72'd0);
        chk("mid_rst_strobes", {67'd0, sle, nr, cle, mem_rd_en, done}, 72'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", 72'(done_cnt - d0), 72'd0);
        n_rst = 1'b1;
        run_frame(1'b0, 1'b0, '0);

        // Random mix of kernel updates and spurious starts.
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(1, 0) == 1) write_coeff({$urandom(), $urandom(), 8'($urandom())});
            run_frame(1'($urandom_range(1, 0)), 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_feeder.md
Name: conv_feeder

Overview:
- Master-side sequencer that drives the convolution controller's request interface: `sample_load_en`, `new_row` and `coeff_load_en`.
- Walks a row-major image of 3-pixel column words held in an external line memory, presents sample and coefficient data, and paces every request on `modwait`.
- Sits between the host frame/coefficient interface and the convolution datapath.
- Coefficient updates commit at the end of a frame and take effect from the next frame, because the controller accepts `coeff_load_en` only in its CONVOLVE state.

Parameters:
- IMG_W, 8, image width in columns; must be >= 3.
- IMG_H, 8, image height in rows; must be >= 3. Output rows = IMG_H-2.
- DATA_W, 8, pixel and coefficient width.
- ADDR_W, 16, memory address width; must satisfy (IMG_H-2)*IMG_W <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame start; ignored while busy.
- coeff_wr  in  1  host coefficient write strobe.
- coeff_in  in  9*DATA_W  3x3 kernel; column k occupies bits [3*DATA_W*(k+1)-1 : 3*DATA_W*k].
- modwait  in  1  controller busy flag.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  column-word address.
- mem_rdata  in  3*DATA_W  read data, valid the cycle after mem_rd_en.
- sample_load_en  out  1  sample request pulse.
- new_row  out  1  row-start pulse.
- coeff_load_en  out  1  coefficient transfer pulse.
- sample_data  out  3*DATA_W  registered sample column; held until the next load.
- coeff_data  out  3*DATA_W  coefficient column for the current CF cycle; 0 otherwise.
- busy  out  1  high when state != IDLE.
- done  out  1  single-cycle frame-complete pulse.

Behaviour:
- Reset: state IDLE. All outputs, counters, `sample_data`, the coefficient shadow, the snapshot and the pending flag are 0. Reset asserted mid-frame abandons the frame immediately; there is no done pulse.
- Counters:
  - `addr` runs 0..(IMG_H-2)*IMG_W-1 and increments by 1 after each accepted sample (no multiplier).
  - `col` runs 0..IMG_W-1 and wraps to 0 at a row end.
  - `row` runs 0..IMG_H-3.
- Sample sequence, four cycles per column:
  - FETCH: `mem_rd_en`=1, `mem_addr`=`addr`.
  - ISSUE: one request pulse; `sample_data` <= `mem_rdata` at the closing edge, so data is valid during the controller's LOAD cycle.
  - GUARD: one cycle; `modwait` is ignored.
  - WAIT_RDY: hold until `modwait`==0, then advance the counters.
- Pulse type in ISSUE:
  - col 0, row 0: `sample_load_en` only.
  - col 0, row >0: `new_row` only (the controller treats this as its S0 load).
  - all other columns: `sample_load_en` only.
- Exit from WAIT_RDY:
  - If the last column of the last row was just accepted: go to CF_ISSUE when the pending flag is set, else FLUSH.
  - Otherwise go to FETCH.
- FLUSH: `new_row`=1 and `sample_load_en`=1 for one cycle, which returns the controller to IDLE. No memory read. Next state is DONE.
- Coefficient transfer:
  - CF_ISSUE: `coeff_load_en`=1. Snapshot <= shadow. Pending is cleared unless `coeff_wr` is high in the same cycle.
  - CF0, CF1, CF2: `coeff_data` = snapshot column 0, 1, 2 respectively.
  - CF2 is followed by DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `coeff_wr` in any state writes the shadow and sets pending. The snapshot isolates an in-flight transfer from a concurrent write.
- At most one of `sample_load_en`, `new_row`, `coeff_load_en` is high in any cycle, except the FLUSH combination. Requests are never issued while `modwait`=1.
- `start` in IDLE moves to FETCH with `addr`, `col` and `row` cleared. `start` while busy has no effect.

Decomposition:
- Package conv_pkg:
  - feeder state enum: IDLE, FETCH, ISSUE, GUARD, WAIT_RDY, FLUSH, CF_ISSUE, CF0, CF1, CF2, DONE.
  - pulse-kind enum: PK_SAMPLE, PK_NEWROW.
  - constant KERNEL_DIM=3.
- One sub-module, conv_coeff_shadow: the shadow register, snapshot register, pending flag and column mux for `coeff_data`.

Test Plan:
- IMG_W=4, IMG_H=4, memory word = address, `modwait` modelled by a controller: `start` -> reads at `addr` 0..7. Row 0 gives 4 `sample_load_en`. Row 1 gives `new_row` alone with `sample_data`=4, then 3 `sample_load_en`. A FLUSH pulse follows, then `done` exactly once.
- `coeff_wr` with kernel columns 0x010203 / 0x040506 / 0x070809 before `start` -> frame ends with `coeff_load_en`, then `coeff_data` = 0x010203, 0x040506, 0x070809 on three consecutive cycles, then `done`. No FLUSH.
- `modwait` forced high for 5 extra cycles after one GUARD -> no pulse or read until it drops; `addr` does not advance.
- `coeff_wr` with a new kernel during CF1 -> the in-flight transfer still sends the old columns, pending stays 1, and the next frame transfers the new kernel.
- Reset asserted in WAIT_RDY at `addr`=5 -> all outputs 0 next cycle, no `done`. A fresh `start` begins at `addr` 0.
- `start` pulsed while busy -> ignored; exactly one `done` and 8 reads.
